alu_exec_unit: RTL
==================

# alu_exec_unit

Execute-stage unit of the RV32I datapath. It consumes the 4-bit `ALUop` produced by the ALU decoder together with the two operands, and returns a registered result. ADD/SUB/logic/compare/COPY_B complete in one cycle. SLL/SRL/SRA run on a serial 1-bit-per-cycle shifter to save area. Valid/ready handshakes on both sides let the pipeline control stall or kill an in-flight operation.

## Interface
- `XLEN`, 32, operand and result width (only 32 is supported; shift amount is `b[4:0]`)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operation offered this cycle
- `in_ready`  out  1  unit will accept on this edge
- `alu_op`  in  4  `ALU_*` encoding from `ALUop.vh`
- `a`  in  XLEN  operand A (rs1/PC)
- `b`  in  XLEN  operand B (rs2/imm)
- `kill`  in  1  abort any in-flight or pending-result operation
- `out_valid`  out  1  `result` holds a completed operation
- `out_ready`  in  1  consumer takes result on this edge
- `result`  out  XLEN  registered result

## Operation
- States: IDLE, SHIFT, DONE.
- Accept condition: `in_valid && in_ready && !kill`. The unit captures `alu_op`, `a`, `b`.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and `out_ready`, and is 0 while `reset` is high.
- Non-shift accept: compute the result, go to DONE.
  - ADD: a+b mod 2^32
  - SUB: a−b mod 2^32
  - AND/OR/XOR: bitwise
  - SLT: signed a<b → 1 else 0
  - SLTU: unsigned a<b → 1 else 0
  - COPY_B: b
  - ALU_XXX or any unlisted code: 0
- Shift accept: load the shift register with `a` and the counter with `b[4:0]`.
  - If the count is 0, go straight to DONE with `result` = a.
  - Otherwise go to SHIFT.
- SHIFT: each cycle shift by 1 and decrement the counter.
  - SLL fills with 0; SRL fills with 0; SRA fills with the current MSB.
  - When the counter reaches 1, the final shift is written to `result` and the state moves to DONE.
- DONE: `out_valid`=1 and `result` is stable until the handshake.
  - `out_ready`=1 without a new accept: go to IDLE.
  - `out_ready`=1 with a simultaneous accept: process the new op as above (back-to-back, no bubble).
- `kill` (any state): next state IDLE, `out_valid` 0 next cycle, the counter is cleared and no accept occurs that cycle. `kill` has priority over accept and over the output handshake.
- Bits `b[31:5]` are ignored for shifts.

## Timing
- Reset values: state IDLE, `out_valid` 0, `result` 0, internal shift register/counter 0. Reset mid-shift discards the operation; `in_ready` is 1 in the first cycle after reset deasserts.
- Non-shift latency: accepted at edge N → `out_valid`=1 after edge N, i.e. visible in cycle N+1.
- Shift latency: shamt s ≥ 1 → `out_valid` visible in cycle N+s+1. s=0 → N+1.
- Sustained throughput: 1 non-shift op/cycle when `out_ready` is held high.
- `result`/`out_valid` are registered outputs and never change while `out_valid && !out_ready && !kill`.
- Inputs are sampled only on the accept edge; they may change freely afterwards.

## Test plan
- Reset then ADD: after `reset` releases, offer ADD a=0x7FFFFFFF, b=1 → next cycle `out_valid`=1, `result`=0x80000000. Follow with SUB a=0, b=1 back-to-back → `result`=0xFFFFFFFF the cycle after.
- Compare: SLT a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0. COPY_B b=0x12345000 → 0x12345000. ALU_XXX → 0.
- Serial shifts:
  - SRA a=0x80000000, b=31 → `in_ready`=0 for 31 cycles, then `result`=0xFFFFFFFF at cycle N+32.
  - SRL with the same operands → 0x00000001.
  - SLL a=1, b=0x25 (shamt 5) → 0x20 at N+6.
  - Shamt 0 → `result`=a at N+1.
- Backpressure: hold `out_ready`=0 for 4 cycles after an XOR completes → `result`/`out_valid` stable and `in_ready`=0. Raise `out_ready` together with a new `in_valid` → transfer and accept on the same edge.
- Kill:
  - Assert `kill` in cycle 3 of SLL shamt 10 → `out_valid` stays 0, `in_ready`=1 next cycle, and a subsequent ADD 2+3 returns 5.
  - `kill` asserted together with `in_valid` → the op is not accepted.
- Reset mid-shift: assert `reset` during SRA shamt 20 → `out_valid`=0, `result`=0 after the edge; no stale result appears later.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: handshake bundle between the pipeline control and alu_exec_unit.
//   in_valid/in_ready : operation offer / acceptance
//   alu_op, a, b      : operation code and operands, sampled on the accept edge
//   kill              : abort whatever the unit is holding or computing
//   out_valid/out_ready, result : completed-result handshake
// master = pipeline side, slave = execution unit side.
interface alu_exec_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, alu_op, a, b, kill, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, alu_op, a, b, kill, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I execute-stage ALU with a registered result.
// ADD/SUB/AND/OR/XOR/SLT/SLTU/COPY_B complete in one cycle; SLL/SRL/SRA go through a
// serial shifter that moves one bit per cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : alu_exec_unit_if slave (in/out valid-ready handshakes, kill, operands, result)
module alu_exec_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic            clk,
  input logic            reset,
  alu_exec_unit_if.slave bus
);

  // ALU operation encoding shared with the ALU decoder.
  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluAnd   = 4'd2;
  localparam logic [3:0] AluOr    = 4'd3;
  localparam logic [3:0] AluXor   = 4'd4;
  localparam logic [3:0] AluSlt   = 4'd5;
  localparam logic [3:0] AluSll   = 4'd6;
  localparam logic [3:0] AluSltu  = 4'd7;
  localparam logic [3:0] AluSrl   = 4'd8;
  localparam logic [3:0] AluSra   = 4'd9;
  localparam logic [3:0] AluCopyB = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] shreg_q;
  logic [4:0]      cnt_q;
  logic [3:0]      op_q;

  logic            accept;
  logic            is_shift;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] shifted;

  assign accept   = bus.in_valid && bus.in_ready && !bus.kill;
  assign shamt    = bus.b[4:0];
  assign is_shift = (bus.alu_op == AluSll) || (bus.alu_op == AluSrl) ||
                    (bus.alu_op == AluSra);

  // Single-cycle operations.
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      AluAdd:   alu_res = bus.a + bus.b;
      AluSub:   alu_res = bus.a - bus.b;
      AluAnd:   alu_res = bus.a & bus.b;
      AluOr:    alu_res = bus.a | bus.b;
      AluXor:   alu_res = bus.a ^ bus.b;
      AluSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      AluSltu:  alu_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      AluCopyB: alu_res = bus.b;
      default:  alu_res = '0;
    endcase
  end

  // One step of the serial shifter; op_q only ever holds a shift code while shifting.
  always_comb begin
    shifted = shreg_q;
    case (op_q)
      AluSll:  shifted = {shreg_q[XLEN-2:0], 1'b0};
      AluSrl:  shifted = {1'b0, shreg_q[XLEN-1:1]};
      default: shifted = {shreg_q[XLEN-1], shreg_q[XLEN-1:1]};
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Accept is only possible in StIdle or in StDone with out_ready,
  // so it is handled ahead of the per-state cases. kill beats everything.
  always_comb begin
    state_d = state_q;
    if (bus.kill) begin
      state_d = StIdle;
    end else if (accept) begin
      state_d = (is_shift && (shamt != 5'd0)) ? StShift : StDone;
    end else begin
      case (state_q)
        StShift: if (cnt_q == 5'd1) state_d = StDone;
        StDone:  if (bus.out_ready) state_d = StIdle;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs. in_ready is forced low during reset so nothing is taken on a reset edge.
  always_comb begin
    bus.in_ready  = !reset && ((state_q == StIdle) ||
                               ((state_q == StDone) && bus.out_ready));
    bus.out_valid = (state_q == StDone);
    bus.result    = result_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
    end else if (bus.kill) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q <= bus.alu_op;
      if (is_shift) begin
        shreg_q <= bus.a;
        cnt_q   <= shamt;
        // Zero shift amount finishes immediately with the unshifted operand.
        if (shamt == 5'd0) result_q <= bus.a;
      end else begin
        result_q <= alu_res;
      end
    end else if (state_q == StShift) begin
      shreg_q <= shifted;
      cnt_q   <= cnt_q - 5'd1;
      if (cnt_q == 5'd1) result_q <= shifted;
    end
  end

endmodule
